// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC-update / exception sequencer: FSM states, request types,
// PC-source mux codes and default vector/cause constants.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StExcSave,
        StVecRead,
        StVecAlu,
        StVecLoad,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ReqSeq    = 3'd0,
        ReqBranch = 3'd1,
        ReqJump   = 3'd2,
        ReqJr     = 3'd3,
        ReqEret   = 3'd4,
        ReqExcOvf = 3'd5,
        ReqExcOpc = 3'd6,
        ReqRsvd   = 3'd7
    } req_type_e;

    localparam logic [1:0] PCSRC_ALU_RESULT  = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT     = 2'b01;
    localparam logic [1:0] PCSRC_SHL2_CONCAT = 2'b10;
    localparam logic [1:0] PCSRC_EPC         = 2'b11;

    localparam int unsigned DEF_MEM_LAT      = 2;
    localparam logic [31:0] DEF_VEC_OPC_ADDR = 32'd253;
    localparam logic [31:0] DEF_VEC_OVF_ADDR = 32'd254;
    localparam logic [31:0] DEF_CAUSE_OPC    = 32'd0;
    localparam logic [31:0] DEF_CAUSE_OVF    = 32'd1;

    function automatic logic is_exc(input req_type_e t);
        return (t == ReqExcOvf) || (t == ReqExcOpc);
    endfunction

endpackage

// File: rtl/pc_seq_lat_cnt.sv
// Loadable down-counter with zero flag; times the vector-fetch memory read.
module pc_seq_lat_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC-update and exception sequencer: drives the PC-source select and the
// PC/EPC/Cause write enables for normal updates and the vectored exception path.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT      = DEF_MEM_LAT,
    parameter logic [31:0] VEC_OPC_ADDR = DEF_VEC_OPC_ADDR,
    parameter logic [31:0] VEC_OVF_ADDR = DEF_VEC_OVF_ADDR,
    parameter logic [31:0] CAUSE_OPC    = DEF_CAUSE_OPC,
    parameter logic [31:0] CAUSE_OVF    = DEF_CAUSE_OVF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [2:0]  i_req_type,
    input  logic        i_cond_true,
    output logic [1:0]  o_pc_src,
    output logic        o_pc_write,
    output logic        o_epc_write,
    output logic        o_cause_write,
    output logic [31:0] o_cause,
    output logic        o_alu_pcm4,
    output logic        o_mem_rd,
    output logic [31:0] o_mem_addr,
    output logic        o_alu_vec,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_in_handler,
    output logic        o_halt
);

    localparam int unsigned    CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_e    r_state;
    state_e    w_state_next;
    req_type_e r_type;
    logic      r_in_handler;
    logic      w_cnt_zero;
    req_type_e w_req_type;

    assign w_req_type = req_type_e'(i_req_type);

    pc_seq_lat_cnt #(
        .WIDTH (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state == StExcSave),
        .i_load_val (CNT_INIT),
        .i_dec      (r_state == StVecRead),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_type       <= ReqSeq;
            r_in_handler <= 1'b0;
        end else begin
            if ((r_state == StIdle) && i_req_valid) begin
                r_type <= w_req_type;
            end
            if (r_state == StExcSave) begin
                r_in_handler <= 1'b1;
            end else if ((r_state == StExec) && (r_type == ReqEret)) begin
                r_in_handler <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (is_exc(w_req_type)) begin
                        // A second exception before ERET is a double fault
                        w_state_next = r_in_handler ? StHalt : StExcSave;
                    end else begin
                        w_state_next = StExec;
                    end
                end
            end
            StExec:    w_state_next = StIdle;
            StExcSave: w_state_next = StVecRead;
            StVecRead: w_state_next = w_cnt_zero ? StVecAlu : StVecRead;
            StVecAlu:  w_state_next = StVecLoad;
            StVecLoad: w_state_next = StIdle;
            StHalt:    w_state_next = StHalt;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_pc_src      = PCSRC_ALU_RESULT;
        o_pc_write    = 1'b0;
        o_epc_write   = 1'b0;
        o_cause_write = 1'b0;
        o_cause       = '0;
        o_alu_pcm4    = 1'b0;
        o_mem_rd      = 1'b0;
        o_mem_addr    = '0;
        o_alu_vec     = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_halt        = 1'b0;
        unique case (r_state)
            StIdle: ;
            StExec: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                case (r_type)
                    ReqBranch: begin
                        o_pc_src   = PCSRC_ALU_OUT;
                        o_pc_write = i_cond_true;
                    end
                    ReqJump: begin
                        o_pc_src   = PCSRC_SHL2_CONCAT;
                        o_pc_write = 1'b1;
                    end
                    ReqEret: begin
                        o_pc_src   = PCSRC_EPC;
                        o_pc_write = 1'b1;
                    end
                    default: begin
                        o_pc_src   = PCSRC_ALU_RESULT;
                        o_pc_write = 1'b1;
                    end
                endcase
            end
            StExcSave: begin
                o_busy        = 1'b1;
                o_alu_pcm4    = 1'b1;
                o_epc_write   = 1'b1;
                o_cause_write = 1'b1;
                o_cause       = (r_type == ReqExcOvf) ? CAUSE_OVF : CAUSE_OPC;
            end
            StVecRead: begin
                o_busy     = 1'b1;
                o_mem_rd   = 1'b1;
                o_mem_addr = (r_type == ReqExcOvf) ? VEC_OVF_ADDR : VEC_OPC_ADDR;
            end
            StVecAlu: begin
                o_busy    = 1'b1;
                o_alu_vec = 1'b1;
            end
            StVecLoad: begin
                o_busy     = 1'b1;
                o_pc_src   = PCSRC_ALU_OUT;
                o_pc_write = 1'b1;
                o_done     = 1'b1;
            end
            StHalt: o_halt = 1'b1;
            default: ;
        endcase
    end

    assign o_in_handler = r_in_handler;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a transaction-level model queues the expected
// per-cycle outputs of each request; a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam int unsigned MEM_LAT = 2;

    typedef struct packed {
        logic        chk;
        logic [1:0]  pc_src;
        logic        pc_write;
        logic        epc_write;
        logic        cause_write;
        logic [31:0] cause;
        logic        alu_pcm4;
        logic        mem_rd;
        logic [31:0] mem_addr;
        logic        alu_vec;
        logic        busy;
        logic        done;
        logic        in_handler;
        logic        halt;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [2:0]  i_req_type;
    logic        i_cond_true;
    logic [1:0]  o_pc_src;
    logic        o_pc_write;
    logic        o_epc_write;
    logic        o_cause_write;
    logic [31:0] o_cause;
    logic        o_alu_pcm4;
    logic        o_mem_rd;
    logic [31:0] o_mem_addr;
    logic        o_alu_vec;
    logic        o_busy;
    logic        o_done;
    logic        o_in_handler;
    logic        o_halt;

    pc_sequencer #(
        .MEM_LAT      (MEM_LAT),
        .VEC_OPC_ADDR (32'd253),
        .VEC_OVF_ADDR (32'd254),
        .CAUSE_OPC    (32'd0),
        .CAUSE_OVF    (32'd1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .i_req_type    (i_req_type),
        .i_cond_true   (i_cond_true),
        .o_pc_src      (o_pc_src),
        .o_pc_write    (o_pc_write),
        .o_epc_write   (o_epc_write),
        .o_cause_write (o_cause_write),
        .o_cause       (o_cause),
        .o_alu_pcm4    (o_alu_pcm4),
        .o_mem_rd      (o_mem_rd),
        .o_mem_addr    (o_mem_addr),
        .o_alu_vec     (o_alu_vec),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_in_handler  (o_in_handler),
        .o_halt        (o_halt)
    );

    always #5 clk = ~clk;

    snap_t exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Model state: architectural flags only
    logic m_in_handler = 1'b0;
    logic m_halted     = 1'b0;

    always @(negedge clk) begin
        snap_t e;
        snap_t a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{chk: 1'b1, pc_src: o_pc_src, pc_write: o_pc_write, epc_write: o_epc_write,
                   cause_write: o_cause_write, cause: o_cause, alu_pcm4: o_alu_pcm4,
                   mem_rd: o_mem_rd, mem_addr: o_mem_addr, alu_vec: o_alu_vec, busy: o_busy,
                   done: o_done, in_handler: o_in_handler, halt: o_halt};
            if (e.chk) begin
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %h required %h", nm, $time, a, e);
                end
            end
        end
    end

    function automatic snap_t idle_snap();
        snap_t s = '0;
        s.chk        = 1'b1;
        s.in_handler = m_in_handler;
        s.halt       = m_halted;
        return s;
    endfunction

    function automatic snap_t busy_snap();
        snap_t s = idle_snap();
        s.busy = 1'b1;
        return s;
    endfunction

    task automatic step(input logic v, input logic [2:0] t, input logic c, input logic rst,
                        input snap_t e, input string nm);
        i_req_valid = v;
        i_req_type  = t;
        i_cond_true = c;
        reset       = rst;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // cmode: 0/1 forces i_cond_true during EXEC, 2 randomises it
    task automatic issue(input logic [2:0] t, input int cmode, input string nm);
        snap_t e;
        logic  c;
        step(1'b1, t, rbit(), 1'b0, idle_snap(), {nm, "_accept"});
        if (m_halted) return;
        if (t == 3'd5 || t == 3'd6) begin
            if (m_in_handler) begin
                m_halted = 1'b1;
                return;
            end
            e = busy_snap();
            e.alu_pcm4    = 1'b1;
            e.epc_write   = 1'b1;
            e.cause_write = 1'b1;
            e.cause       = (t == 3'd5) ? 32'd1 : 32'd0;
            step(1'b0, 3'($urandom_range(0, 7)), rbit(), 1'b0, e, {nm, "_save"});
            m_in_handler = 1'b1;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                e = busy_snap();
                e.mem_rd   = 1'b1;
                e.mem_addr = (t == 3'd5) ? 32'd254 : 32'd253;
                step(1'b0, 3'($urandom_range(0, 7)), rbit(), 1'b0, e, {nm, "_vecrd"});
            end
            e = busy_snap();
            e.alu_vec = 1'b1;
            step(1'b0, 3'($urandom_range(0, 7)), rbit(), 1'b0, e, {nm, "_vecalu"});
            e = busy_snap();
            e.pc_src   = 2'b01;
            e.pc_write = 1'b1;
            e.done     = 1'b1;
            step(1'b0, 3'($urandom_range(0, 7)), rbit(), 1'b0, e, {nm, "_vecload"});
        end else begin
            c = (cmode == 2) ? rbit() : (cmode == 1);
            e = busy_snap();
            e.done = 1'b1;
            case (t)
                3'd1: begin e.pc_src = 2'b01; e.pc_write = c;    end
                3'd2: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
                3'd4: begin e.pc_src = 2'b11; e.pc_write = 1'b1; end
                default: begin e.pc_src = 2'b00; e.pc_write = 1'b1; end
            endcase
            step(1'b0, 3'($urandom_range(0, 7)), c, 1'b0, e, {nm, "_exec"});
            if (t == 3'd4) m_in_handler = 1'b0;
        end
    endtask

    // Reset from IDLE or HALT: outputs during the reset cycle still show that state
    task automatic do_reset(input string nm);
        step(1'b0, 3'd0, 1'b0, 1'b1, idle_snap(), {nm, "_rst"});
        m_in_handler = 1'b0;
        m_halted     = 1'b0;
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)), rbit(), 1'b0, idle_snap(), nm);
        end
    endtask

    initial begin
        snap_t s;
        int    wait_cycles;
        reset       = 1'b1;
        i_req_valid = 1'b0;
        i_req_type  = 3'd0;
        i_cond_true = 1'b0;
        @(posedge clk);
        #1;
        s = '0;
        step(1'b0, 3'd0, 1'b0, 1'b1, s, "por");

        n_checks++;
        if ((o_pc_src !== 2'b00) || (o_pc_write !== 1'b0) || (o_epc_write !== 1'b0) ||
            (o_cause_write !== 1'b0) || (o_cause !== 32'd0) || (o_alu_pcm4 !== 1'b0) ||
            (o_mem_rd !== 1'b0) || (o_mem_addr !== 32'd0) || (o_alu_vec !== 1'b0) ||
            (o_busy !== 1'b0) || (o_done !== 1'b0) || (o_in_handler !== 1'b0) ||
            (o_halt !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state_direct @%0t: outputs not all zero after reset", $time);
        end

        idle(2, "reset_state");

        issue(3'd0, 2, "seq");
        idle(1, "seq_idle");
        issue(3'd1, 0, "br_nt");
        issue(3'd1, 1, "br_t");
        issue(3'd2, 2, "jump");
        issue(3'd3, 2, "jr");
        issue(3'd7, 2, "rsvd");
        issue(3'd4, 2, "eret_nohandler");
        idle(1, "gap");

        issue(3'd5, 2, "exc_ovf");
        issue(3'd4, 2, "eret1");
        issue(3'd6, 2, "exc_opc");
        issue(3'd5, 2, "dbl_fault");
        idle(2, "halt");
        issue(3'd0, 2, "halt_ignored");
        do_reset("halt");
        idle(1, "post_halt");

        issue(3'd6, 2, "exc_opc1");
        issue(3'd4, 2, "eret2");
        issue(3'd6, 2, "exc_opc2");
        issue(3'd4, 2, "eret3");

        // Reset while in VEC_READ: sequence aborts, no PC write afterwards
        step(1'b1, 3'd5, 1'b0, 1'b0, idle_snap(), "abort_accept");
        s = busy_snap();
        s.alu_pcm4 = 1'b1; s.epc_write = 1'b1; s.cause_write = 1'b1; s.cause = 32'd1;
        step(1'b0, 3'd0, 1'b0, 1'b0, s, "abort_save");
        m_in_handler = 1'b1;
        s = busy_snap();
        s.mem_rd = 1'b1; s.mem_addr = 32'd254;
        step(1'b0, 3'd0, 1'b0, 1'b1, s, "abort_vecrd_rst");
        m_in_handler = 1'b0;
        idle(4, "abort_after");

        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 9);
            logic [2:0] t = (r < 8) ? 3'(r) : 3'd4;
            issue(t, 2, "rand");
            if (m_halted) begin
                idle($urandom_range(0, 2), "rand_halt");
                do_reset("rand");
            end
            idle($urandom_range(0, 2), "rand_gap");
        end

        i_req_valid = 1'b0;
        wait_cycles = 0;
        while ((exp_q.size() > 0) && (wait_cycles < 16)) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout @%0t: %0d expectations never compared", $time,
                     exp_q.size());
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL too_few_checks: only %0d comparisons evaluated", n_checks);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
